// File: rtl/pit_cfg_sequencer.sv
// rtl/pit_cfg_sequencer.sv - wishbone master that programs and runs a pit_top for N rollover periods
module pit_cfg_sequencer #(
    parameter int A_WIDTH     = 3,
    parameter int BASE_ADR    = 0,
    parameter int ACK_TIMEOUT = 16,
    parameter int POLL_GAP    = 4
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        cfg_mod,
    input  logic [3:0]         cfg_ps,
    input  logic               cfg_irqen,
    input  logic [7:0]         cfg_periods,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [7:0]         period_cnt,
    output logic [A_WIDTH-1:0] wbm_adr_o,
    output logic [15:0]        wbm_dat_o,
    input  logic [15:0]        wbm_dat_i,
    output logic               wbm_we_o,
    output logic               wbm_stb_o,
    output logic               wbm_cyc_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_MOD, S_WR_CTL, S_POLL_RD, S_GAP, S_CLR, S_STOP, S_FIN
    } state_t;

    localparam logic [A_WIDTH-1:0] ADR_CNTRL = A_WIDTH'(BASE_ADR);
    localparam logic [A_WIDTH-1:0] ADR_MOD   = A_WIDTH'(BASE_ADR + 1);
    localparam logic [15:0]        ENA       = 16'h0001;
    localparam logic [15:0]        FLAG      = 16'h0004;

    state_t             state_q, state_d;
    logic [15:0]        mod_q;
    logic [3:0]         ps_q;
    logic               irqen_q;
    logic [7:0]         periods_q;
    logic               busy_q, done_q, err_q, abort_q;
    logic [7:0]         cnt_q;
    logic [A_WIDTH-1:0] adr_q;
    logic [15:0]        dat_q;
    logic               we_q, stb_q;
    logic [7:0]         tmo_q, gap_q;

    logic [15:0]        ctl_w;
    logic               bus_ok, bus_fail, stop_req;
    logic [A_WIDTH-1:0] launch_adr;
    logic [15:0]        launch_dat;
    logic               launch_we;

    assign ctl_w    = {4'b0, ps_q, 6'b0, irqen_q, 1'b0};
    // err_i dominates a coincident ack; a missing ack ends the cycle on its last allowed beat
    assign bus_fail = stb_q && (wbm_err_i || (!wbm_ack_i && tmo_q == 8'(ACK_TIMEOUT - 1)));
    assign bus_ok   = stb_q && wbm_ack_i && !wbm_err_i;
    assign stop_req = abort_q || (abort && busy_q);

    always_comb begin
        launch_adr = ADR_CNTRL;
        launch_dat = 16'h0000;
        launch_we  = 1'b0;
        case (state_q)
            S_WR_MOD: begin launch_adr = ADR_MOD; launch_dat = mod_q;               launch_we = 1'b1; end
            S_WR_CTL: begin launch_dat = ctl_w | ENA;                               launch_we = 1'b1; end
            S_CLR:    begin launch_dat = ctl_w | FLAG | ENA;                        launch_we = 1'b1; end
            S_STOP:   begin launch_dat = 16'h0000;                                  launch_we = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WR_MOD:  state_d = S_WR_CTL;
            S_WR_CTL:  state_d = S_POLL_RD;
            S_POLL_RD: state_d = wbm_dat_i[2] ? S_CLR : ((POLL_GAP == 0) ? S_POLL_RD : S_GAP);
            S_CLR:     state_d = (periods_q != 8'd0 && cnt_q + 8'd1 == periods_q) ? S_STOP : S_POLL_RD;
            S_STOP:    state_d = S_FIN;
            default:   state_d = S_IDLE;
        endcase
        if (stop_req && state_q != S_STOP)
            state_d = S_STOP;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= S_IDLE;
            mod_q     <= '0;
            ps_q      <= '0;
            irqen_q   <= 1'b0;
            periods_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            tmo_q     <= '0;
            gap_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && abort && state_q != S_STOP && state_q != S_FIN)
                abort_q <= 1'b1;
            if (stb_q)
                tmo_q <= tmo_q + 8'd1;
            case (state_q)
                S_IDLE: if (start) begin
                    mod_q     <= cfg_mod;
                    ps_q      <= cfg_ps;
                    irqen_q   <= cfg_irqen;
                    periods_q <= cfg_periods;
                    busy_q    <= 1'b1;
                    err_q     <= 1'b0;
                    abort_q   <= 1'b0;
                    cnt_q     <= '0;
                    adr_q     <= ADR_MOD;
                    dat_q     <= cfg_mod;
                    we_q      <= 1'b1;
                    stb_q     <= 1'b1;
                    tmo_q     <= '0;
                    state_q   <= S_WR_MOD;
                end
                S_GAP: begin
                    gap_q <= gap_q + 8'd1;
                    if (stop_req)
                        state_q <= S_STOP;
                    else if (gap_q == 8'(POLL_GAP - 1))
                        state_q <= S_POLL_RD;
                end
                S_FIN: begin
                    abort_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    if (!stb_q) begin
                        adr_q <= launch_adr;
                        dat_q <= launch_dat;
                        we_q  <= launch_we;
                        stb_q <= 1'b1;
                        tmo_q <= '0;
                    end else if (bus_fail) begin
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_FIN;
                    end else if (bus_ok) begin
                        stb_q   <= 1'b0;
                        gap_q   <= '0;
                        state_q <= state_d;
                        if (state_q == S_CLR)
                            cnt_q <= cnt_q + 8'd1;
                        if (state_d == S_FIN) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign period_cnt = cnt_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_we_o   = we_q;
    assign wbm_stb_o  = stb_q;
    assign wbm_cyc_o  = stb_q;
endmodule

// File: tb/tb_pit_cfg_sequencer.sv
// tb/tb_pit_cfg_sequencer.sv - randomized self-checking bench with a behavioural PIT slave
module tb_pit_cfg_sequencer;
    localparam int POLL_GAP = 4;
    localparam int ACK_TO   = 16;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] cfg_mod = '0;
    logic [3:0]  cfg_ps = '0;
    logic        cfg_irqen = 1'b0;
    logic [7:0]  cfg_periods = '0;
    logic        busy, done, err;
    logic [7:0]  period_cnt;
    logic [2:0]  wbm_adr_o;
    logic [15:0] wbm_dat_o;
    logic [15:0] wbm_dat_i = '0;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;

    int errors = 0, checks = 0;

    pit_cfg_sequencer #(.A_WIDTH(3), .BASE_ADR(0), .ACK_TIMEOUT(ACK_TO), .POLL_GAP(POLL_GAP)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .abort(abort),
        .cfg_mod(cfg_mod), .cfg_ps(cfg_ps), .cfg_irqen(cfg_irqen), .cfg_periods(cfg_periods),
        .busy(busy), .done(done), .err(err), .period_cnt(period_cnt),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // slave / monitor state
    logic [18:0] wlog[$];
    int   txn, err_at, lat, polls_left, idle, done_pulses, bus_viol, gap_viol;
    bit   noack, in_cyc, last_rd_noflag, prev_stb;
    logic [19:0] prev_bus;

    initial begin
        txn = 0; err_at = -1; lat = 0; polls_left = 0; idle = 100; done_pulses = 0;
        bus_viol = 0; gap_viol = 0; noack = 0; in_cyc = 0; last_rd_noflag = 0; prev_stb = 0;
        prev_bus = '0;
    end

    always @(negedge wb_clk) begin
        if (wbm_ack_i && wbm_stb_o) bus_viol++;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 16'h0000;
        if (wbm_stb_o !== wbm_cyc_o) bus_viol++;
        if (wbm_stb_o && prev_stb && {wbm_adr_o, wbm_dat_o, wbm_we_o} !== prev_bus) bus_viol++;
        if (wbm_stb_o && !prev_stb) begin
            if (idle < 1) bus_viol++;
            if (last_rd_noflag && !wbm_we_o && idle < POLL_GAP) gap_viol++;
            if (!wbm_we_o && (wbm_adr_o != 3'd0 || wbm_dat_o != 16'h0)) bus_viol++;
        end
        idle = wbm_stb_o ? 0 : idle + 1;
        if (done) done_pulses++;
        prev_stb = wbm_stb_o;
        prev_bus = {wbm_adr_o, wbm_dat_o, wbm_we_o};
        if (!wbm_stb_o) in_cyc = 0;
        else begin
            if (!in_cyc) begin
                in_cyc = 1;
                lat = $urandom_range(0, 3);
                txn++;
            end
            if (!noack) begin
                if (txn == err_at) begin
                    wbm_ack_i = 1'b1;
                    wbm_err_i = 1'b1;
                    in_cyc = 0;
                end else if (lat == 0) begin
                    wbm_ack_i = 1'b1;
                    in_cyc = 0;
                    if (wbm_we_o) begin
                        wlog.push_back({wbm_adr_o, wbm_dat_o});
                        last_rd_noflag = 0;
                    end else if (polls_left == 0) begin
                        wbm_dat_i = 16'h0005;
                        polls_left = $urandom_range(0, 3);
                        last_rd_noflag = 0;
                    end else begin
                        polls_left--;
                        wbm_dat_i = 16'h0001;
                        last_rd_noflag = 1;
                    end
                end else lat--;
            end
        end
    end

    task automatic start_cfg(input logic [15:0] m, input logic [3:0] ps, input logic irq, input logic [7:0] per);
        wlog.delete();
        txn = 0;
        done_pulses = 0;
        polls_left = $urandom_range(0, 3);
        cfg_mod = m; cfg_ps = ps; cfg_irqen = irq; cfg_periods = per;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_mod = $urandom; cfg_ps = 4'($urandom); cfg_irqen = 1'($urandom); cfg_periods = 8'($urandom);
        chk("start_busy", busy, 1);
        chk("start_stb", {wbm_stb_o, wbm_cyc_o, wbm_we_o}, 3'b111);
        chk("start_adr", wbm_adr_o, 1);
        chk("start_dat", wbm_dat_o, m);
        chk("start_err", err, 0);
        chk("start_cnt", period_cnt, 0);
    endtask

    task automatic wait_done(input int abort_at);
        int n = 0;
        while (!done && n < 4000) begin
            if (abort_at >= 0 && int'(period_cnt) >= abort_at) abort = 1'b1;
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        chk("done_busy", busy, 0);
        tick();
        abort = 1'b0;
        chk("done_width", done, 0);
        chk("done_count", done_pulses, 1);
    endtask

    // expected write stream: MOD, enable, one clear per completed period, final disable
    task automatic check_writes(input logic [15:0] m, input logic [3:0] ps, input logic irq, input int k);
        logic [18:0] exp[$];
        int ctl;
        ctl = int'(ps) * 256 + int'(irq) * 2;
        exp.push_back({3'd1, m});
        exp.push_back({3'd0, 16'(ctl + 1)});
        for (int i = 0; i < k; i++) exp.push_back({3'd0, 16'(ctl + 5)});
        exp.push_back({3'd0, 16'h0000});
        chk("wr_len", wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++)
            chk($sformatf("wr%0d", i), wlog[i], exp[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {busy, done, err, wbm_stb_o, wbm_cyc_o, wbm_we_o}, 0);
        chk({tag, "_cnt"}, period_cnt, 0);
        chk({tag, "_bus"}, {wbm_adr_o, wbm_dat_o}, 0);
    endtask

    initial begin
        logic [15:0] m;
        logic [3:0]  ps;
        logic        irq;
        logic [7:0]  per;
        int          n, pc;

        repeat (3) tick();
        check_idle_outputs("reset");
        wb_rst = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        start_cfg(16'h0010, 4'd0, 1'b0, 8'd2);
        wait_done(-1);
        check_writes(16'h0010, 4'd0, 1'b0, 2);
        chk("t1_cnt", period_cnt, 2);
        chk("t1_err", err, 0);

        start_cfg(16'h0004, 4'd2, 1'b1, 8'd1);
        wait_done(-1);
        check_writes(16'h0004, 4'd2, 1'b1, 1);
        chk("t2_cnt", period_cnt, 1);

        for (int it = 0; it < 5; it++) begin
            m = 16'($urandom); ps = 4'($urandom); irq = 1'($urandom); per = 8'($urandom_range(1, 4));
            start_cfg(m, ps, irq, per);
            wait_done(-1);
            check_writes(m, ps, irq, int'(per));
            chk("rnd_cnt", period_cnt, per);
            chk("rnd_err", err, 0);
        end

        start_cfg(16'h0003, 4'd0, 1'b0, 8'd0);
        wait_done(5);
        pc = int'(period_cnt);
        chk("abort_cnt_ok", (pc == 5 || pc == 6), 1);
        check_writes(16'h0003, 4'd0, 1'b0, pc);
        chk("abort_err", err, 0);

        noack = 1;
        start_cfg(16'h0007, 4'd1, 1'b0, 8'd1);
        n = 0;
        while (wbm_stb_o && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_stb_cycles", n, ACK_TO);
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        tick();
        chk("tmo_done_width", done, 0);
        chk("tmo_err_sticky", err, 1);
        chk("tmo_no_writes", wlog.size(), 0);
        noack = 0;
        repeat (3) tick();
        start_cfg(16'h0009, 4'd0, 1'b0, 8'd1);
        wait_done(-1);
        check_writes(16'h0009, 4'd0, 1'b0, 1);

        err_at = 2;
        start_cfg(16'h0022, 4'd3, 1'b0, 8'd2);
        wait_done(-1);
        err_at = -1;
        chk("berr_err", err, 1);
        chk("berr_writes", wlog.size(), 1);

        start_cfg(16'h0011, 4'd0, 1'b0, 8'd3);
        n = 0;
        while (!(wbm_stb_o && !wbm_we_o) && n < 300) begin n++; tick(); end
        chk("rst_reached_poll", wbm_stb_o && !wbm_we_o, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n = 0;
        while (!(wbm_stb_o && !wbm_we_o) && n < 300) begin n++; tick(); end
        chk("rst_second_poll", wbm_stb_o && !wbm_we_o, 1);
        chk("rst_busy_before", busy, 1);
        wb_rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        wb_rst = 1'b0;
        repeat (20) tick();
        check_idle_outputs("after_midrst");
        chk("midrst_no_done", done_pulses, 0);
        n = 0;
        foreach (wlog[i]) if (wlog[i][18:16] == 3'd1) n++;
        chk("restart_ignored", n, 1);

        chk("bus_protocol", bus_viol, 0);
        chk("poll_gap", gap_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
